noise_source: RTL and testbench
===============================

# noise_source

Pseudo-random noise generator that produces the independent biased noise channels consumed by the noise-combining logic: channel k is 1 with probability 1/2^(k+1). It is built on a 32-bit leap-forward LFSR and includes a seed-load port, a warm-up phase and per-channel ones-counters for on-chip bias checking. It sits between the clock/reset domain root and the noise inputs of the combiner, sharing its clock.

## Interface
- SEED, 32'hACE1_2468, LFSR value loaded at reset and substituted for any all-zero seed.
- WARMUP_CYCLES, 4, number of clock edges the LFSR runs before outputs become valid (range 1..255).
- WIN_LOG2, 10, statistics window is 2^WIN_LOG2 valid cycles (range 4..20).
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  advance generator and produce output this cycle.
- seed_load  input  1  single-cycle strobe: load seed_in and restart warm-up.
- seed_in  input  32  new LFSR seed, sampled when seed_load=1.
- nois  output  4  noise channels; nois[k] has P(1)=1/2^(k+1).
- nois_valid  output  1  nois holds a fresh sample this cycle.
- stats_cnt  output  4*(WIN_LOG2+1)  ones count of channel k in bits [k*(WIN_LOG2+1) +: WIN_LOG2+1] for the last completed window.
- stats_valid  output  1  one-cycle pulse when stats_cnt updates.

## Operation
- LFSR step: fb = s[31]^s[21]^s[1]^s[0]; s <= {s[30:0], fb}. Each advancing cycle applies 10 steps combinationally; the fb bits produced are b0 (first) .. b9 (last).
- Channel mapping uses disjoint bits, so channels are mutually independent: nois[0]=b0; nois[1]=b1&b2; nois[2]=b3&b4&b5; nois[3]=b6&b7&b8&b9.
- States: WARMUP, RUN.
  - WARMUP: LFSR advances every cycle regardless of en; a warm-up counter counts edges; after WARMUP_CYCLES edges go to RUN. nois=0, nois_valid=0.
  - RUN, en=1: LFSR advances, nois registered from new bits, nois_valid=1.
  - RUN, en=0: LFSR holds, nois=0, nois_valid=0; window counters hold.
- seed_load (any state, priority over en): s <= (seed_in==0) ? SEED : seed_in; state -> WARMUP, warm-up counter cleared; window counters and cycle count cleared; nois=0, nois_valid=0 next cycle. stats_cnt keeps its last value.
- Statistics: on each cycle registering nois_valid=1, a window cycle counter (WIN_LOG2 bits) increments and each channel counter adds its new nois bit. Counters are WIN_LOG2+1 bits (all-ones window fits without wrap). On the cycle completing 2^WIN_LOG2 valid samples, stats_cnt is loaded with the final totals (including that cycle's bits), stats_valid pulses, window counters restart from 0.
- Reset values: s=SEED, state=WARMUP, warm-up counter 0, nois=0, nois_valid=0, stats_cnt=0, stats_valid=0, all window counters 0.
- LFSR never reaches zero: reset and seed-load guarantee a nonzero state.

## Timing
- All outputs registered; no combinational path from inputs to outputs.
- After rst_n release with en held 1: nois_valid first high after WARMUP_CYCLES+1 rising edges, then high every cycle.
- seed_load at edge t: nois_valid low from t+1; with en=1 high again after WARMUP_CYCLES+1 edges following t.
- en deassert at edge t: nois/nois_valid go 0 at t+1; reassert resumes sequence exactly where it stopped (no samples lost or skipped).
- stats_valid pulse coincides with stats_cnt update, one cycle wide; next pulse no earlier than 2^WIN_LOG2 valid cycles later.
- rst_n assertion mid-operation clears everything immediately (asynchronously), including a pending stats window.

## Test plan
- Reset: hold rst_n=0 -> nois=0, nois_valid=0, stats_valid=0, stats_cnt=0; release with en=1 -> nois_valid rises exactly on edge 5 (WARMUP_CYCLES=4).
- Golden sequence: default SEED, en=1, 1000 cycles -> nois matches bit-exact software model of the 10-step LFSR and AND mapping.
- Bias: WIN_LOG2=16, en=1 -> first stats_valid after 65536 valid cycles; counts within ±3 sigma of 32768, 16384, 8192, 4096; pairwise joint ones count of nois[0]&nois[1] within ±3 sigma of 8192.
- Zero seed: seed_load=1, seed_in=0 mid-RUN -> next 100 samples identical to post-reset sequence; nois_valid low for 5 cycles.
- en gating: toggle en randomly 50% -> concatenated valid samples equal the uninterrupted golden sequence; nois=0 whenever nois_valid=0; window completes only after 2^WIN_LOG2 valid samples.
- Async reset mid-window (e.g. 700 of 1024 valid cycles) -> all outputs 0 immediately, no stats_valid; after warm-up first window completes 1024 valid cycles later.

Source files
------------

// File: rtl/noise_source.sv
// Biased pseudo-random noise channels from a 32-bit leap-forward LFSR (10 steps per advance),
// with seed loading, a warm-up phase and per-channel windowed ones-counters.
`timescale 1ns/1ps
module noise_source #(
    parameter logic [31:0] SEED          = 32'hACE1_2468,
    parameter int          WARMUP_CYCLES = 4,
    parameter int          WIN_LOG2      = 10
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      seed_load,
    input  logic [31:0]               seed_in,
    output logic [3:0]                nois,
    output logic                      nois_valid,
    output logic [4*(WIN_LOG2+1)-1:0] stats_cnt,
    output logic                      stats_valid
);

    localparam int         CW        = WIN_LOG2 + 1;
    localparam logic [7:0] WARM_LAST = 8'(WARMUP_CYCLES - 1);

    typedef enum logic {WARMUP, RUN} state_e;

    state_e                state_q, state_d;
    logic [31:0]           lfsr_q, lfsr_d;
    logic [7:0]            warm_q, warm_d;
    logic [3:0]            nois_q, nois_d;
    logic                  nvld_q, nvld_d;
    logic [WIN_LOG2-1:0]   win_q, win_d;
    logic [3:0][CW-1:0]    ones_q, ones_d;
    logic [3:0][CW-1:0]    stats_q, stats_d;
    logic                  svld_q, svld_d;
    logic [31:0]           lfsr_adv;
    logic [9:0]            fb_bits;
    logic [3:0]            chan;

    // Ten serial LFSR steps unrolled; b[0] is the first feedback bit produced.
    function automatic logic [41:0] leap10(input logic [31:0] s);
        logic [31:0] t;
        logic [9:0]  b;
        t = s;
        b = '0;
        for (int i = 0; i < 10; i++) begin
            b[i] = t[31] ^ t[21] ^ t[1] ^ t[0];
            t    = {t[30:0], b[i]};
        end
        return {b, t};
    endfunction

    assign {fb_bits, lfsr_adv} = leap10(lfsr_q);
    // Disjoint bit groups keep the channels mutually independent.
    assign chan = {&fb_bits[9:6], &fb_bits[5:3], &fb_bits[2:1], fb_bits[0]};

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        warm_d  = warm_q;
        nois_d  = '0;
        nvld_d  = 1'b0;
        win_d   = win_q;
        ones_d  = ones_q;
        stats_d = stats_q;
        svld_d  = 1'b0;
        if (seed_load) begin
            lfsr_d  = (seed_in == 32'd0) ? SEED : seed_in;
            state_d = WARMUP;
            warm_d  = '0;
            win_d   = '0;
            ones_d  = '0;
        end else begin
            case (state_q)
                WARMUP: begin
                    lfsr_d = lfsr_adv;
                    warm_d = warm_q + 8'd1;
                    if (warm_q == WARM_LAST) state_d = RUN;
                end
                RUN: begin
                    if (en) begin
                        lfsr_d = lfsr_adv;
                        nois_d = chan;
                        nvld_d = 1'b1;
                        win_d  = win_q + 1'b1;
                        for (int k = 0; k < 4; k++)
                            ones_d[k] = ones_q[k] + {{WIN_LOG2{1'b0}}, chan[k]};
                        // Last sample of the window: publish totals and restart.
                        if (&win_q) begin
                            stats_d = ones_d;
                            svld_d  = 1'b1;
                            win_d   = '0;
                            ones_d  = '0;
                        end
                    end
                end
                default: state_d = WARMUP;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= WARMUP;
            lfsr_q  <= SEED;
            warm_q  <= '0;
            nois_q  <= '0;
            nvld_q  <= 1'b0;
            win_q   <= '0;
            ones_q  <= '0;
            stats_q <= '0;
            svld_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            warm_q  <= warm_d;
            nois_q  <= nois_d;
            nvld_q  <= nvld_d;
            win_q   <= win_d;
            ones_q  <= ones_d;
            stats_q <= stats_d;
            svld_q  <= svld_d;
        end
    end

    assign nois        = nois_q;
    assign nois_valid  = nvld_q;
    assign stats_cnt   = stats_q;
    assign stats_valid = svld_q;

endmodule

// File: tb/tb_noise_source.sv
// Scoreboard bench for noise_source: golden LFSR samples and window totals are queued
// by the bench and compared as the DUT emits samples and statistics pulses.
`timescale 1ns/1ps
module tb_noise_source;

    localparam int          WL   = 10;
    localparam int          CW   = WL + 1;
    localparam int          WARM = 4;
    localparam logic [31:0] SEED = 32'hACE1_2468;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              en = 1'b0;
    logic              seed_load = 1'b0;
    logic [31:0]       seed_in = '0;
    logic [3:0]        nois;
    logic              nois_valid;
    logic [4*CW-1:0]   stats_cnt;
    logic              stats_valid;

    noise_source #(.SEED(SEED), .WARMUP_CYCLES(WARM), .WIN_LOG2(WL)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .seed_load(seed_load), .seed_in(seed_in),
        .nois(nois), .nois_valid(nois_valid), .stats_cnt(stats_cnt), .stats_valid(stats_valid)
    );

    always #5 clk = ~clk;

    int              n_tests = 0;
    int              n_fail  = 0;
    logic [3:0]      exp_q[$];
    logic [4*CW-1:0] stat_q[$];
    logic [CW-1:0]   acc[4];
    logic [3:0]      e;
    int              win_n = 0;
    int              joint = 0;
    bit              first_done = 1'b0;
    int              nstats = 0;
    logic [4*CW-1:0] last_stats = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_step(input logic [31:0] s, output logic [3:0] smp);
        logic [9:0]  b;
        logic [31:0] t;
        t = s;
        b = '0;
        for (int i = 0; i < 10; i++) begin
            b[i] = t[31] ^ t[21] ^ t[1] ^ t[0];
            t    = {t[30:0], b[i]};
        end
        smp[0] = b[0];
        smp[1] = b[1] & b[2];
        smp[2] = b[3] & b[4] & b[5];
        smp[3] = b[6] & b[7] & b[8] & b[9];
        return t;
    endfunction

    task automatic restart(input logic [31:0] seed);
        logic [31:0] s;
        logic [3:0]  d;
        exp_q.delete();
        stat_q.delete();
        win_n = 0;
        for (int k = 0; k < 4; k++) acc[k] = '0;
        s = (seed == 32'd0) ? SEED : seed;
        for (int i = 0; i < WARM; i++) s = model_step(s, d);
        for (int i = 0; i < 4000; i++) begin
            s = model_step(s, d);
            exp_q.push_back(d);
        end
    endtask

    always @(negedge clk) begin
        if (nois_valid) begin
            if (exp_q.size() == 0) check("sb_underflow", 64'd1, 64'd0);
            else begin
                e = exp_q.pop_front();
                check("nois", 64'(nois), 64'(e));
                for (int k = 0; k < 4; k++) acc[k] = acc[k] + CW'(e[k]);
                if (!first_done) joint = joint + int'(nois[0] & nois[1]);
                win_n++;
                if (win_n == (1 << WL)) begin
                    stat_q.push_back({acc[3], acc[2], acc[1], acc[0]});
                    for (int k = 0; k < 4; k++) acc[k] = '0;
                    win_n = 0;
                    first_done = 1'b1;
                end
            end
        end else begin
            check("nois_idle", 64'(nois), 64'd0);
        end
        if (stats_valid) begin
            if (stat_q.size() == 0) check("stats_unexpected", 64'd1, 64'd0);
            else check("stats_cnt", 64'(stats_cnt), 64'(stat_q.pop_front()));
            nstats++;
            last_stats = stats_cnt;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int              edges;
        int              ns0;
        int              bound;
        bit              seen;
        logic [CW-1:0]   c;
        logic [4*CW-1:0] saved;

        restart(SEED);
        repeat (3) @(negedge clk);
        check("rst_nois", 64'(nois), 64'd0);
        check("rst_valid", 64'(nois_valid), 64'd0);
        check("rst_svalid", 64'(stats_valid), 64'd0);
        check("rst_stats", 64'(stats_cnt), 64'd0);

        en = 1'b1;
        rst_n = 1'b1;
        edges = 0;
        seen = 1'b0;
        while (!seen && edges < 20) begin
            @(posedge clk); #1;
            edges++;
            seen = nois_valid;
        end
        check("first_valid_edge", 64'(edges), 64'(WARM + 1));

        repeat (1100) @(negedge clk);
        #1;
        check("first_window", 64'(nstats), 64'd1);
        c = last_stats[0*CW +: CW]; check("bias_ch0", 64'(c >= 464 && c <= 560), 64'd1);
        c = last_stats[1*CW +: CW]; check("bias_ch1", 64'(c >= 214 && c <= 298), 64'd1);
        c = last_stats[2*CW +: CW]; check("bias_ch2", 64'(c >= 97 && c <= 159), 64'd1);
        c = last_stats[3*CW +: CW]; check("bias_ch3", 64'(c >= 41 && c <= 87), 64'd1);
        check("bias_joint01", 64'(joint >= 97 && joint <= 159), 64'd1);

        // Zero seed mid-run must replay the post-reset sequence.
        saved = stats_cnt;
        seed_in = 32'd0;
        seed_load = 1'b1;
        restart(32'd0);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            seed_load = 1'b0;
            check("seed0_valid", 64'(nois_valid), (i < 5) ? 64'd0 : 64'd1);
        end
        check("stats_hold", 64'(stats_cnt), 64'(saved));
        repeat (150) @(negedge clk);

        #1;
        seed_in = 32'h1357_9BDF;
        seed_load = 1'b1;
        restart(32'h1357_9BDF);
        @(posedge clk); #1;
        seed_load = 1'b0;
        check("seedn_valid", 64'(nois_valid), 64'd0);
        repeat (60) @(negedge clk);

        ns0 = nstats;
        repeat (2500) begin
            @(negedge clk); #1;
            en = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            check("valid_follows_en", 64'(nois_valid), 64'(en));
        end
        @(negedge clk); #1;
        check("gated_window", 64'(nstats > ns0), 64'd1);

        // Asynchronous reset partway through a window.
        en = 1'b1;
        bound = 0;
        while (win_n != 700 && bound < 3000) begin
            @(negedge clk); #1;
            bound++;
        end
        check("reach_700", 64'(win_n), 64'd700);
        ns0 = nstats;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("arst_nois", 64'(nois), 64'd0);
        check("arst_valid", 64'(nois_valid), 64'd0);
        check("arst_svalid", 64'(stats_valid), 64'd0);
        check("arst_stats", 64'(stats_cnt), 64'd0);
        restart(SEED);
        @(negedge clk);
        @(negedge clk); #1;
        rst_n = 1'b1;
        repeat (WARM + (1 << WL) - 1) @(negedge clk);
        #1;
        check("no_early_stats", 64'(nstats), 64'(ns0));
        @(negedge clk); #1;
        check("window_after_reset", 64'(nstats), 64'(ns0 + 1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
